// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C EEPROM-emulating target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCtrl,
    StAckCtrl,
    StAhi,
    StAckAhi,
    StAlo,
    StAckAlo,
    StWdata,
    StAckW,
    StRdata,
    StRack
  } state_e;

  localparam logic        AckBit  = 1'b0;
  localparam logic        NackBit = 1'b1;
  localparam int unsigned BitCntW = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the SCL/SDA pads and derives SCL edge and START/STOP condition pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] metastable stage, [1] synced value, [2] previous synced value
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;

  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_i};
    sda_pipe_d = {sda_pipe_q[1:0], sda_i};
  end

  // Reset to the idle-bus level so no spurious edge is seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
    end
  end

  always_comb begin
    sda_o      = sda_pipe_q[1];
    scl_rise_o = scl_pipe_q[1] & ~scl_pipe_q[2];
    scl_fall_o = ~scl_pipe_q[1] & scl_pipe_q[2];
    start_o    = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
    stop_o     = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];
  end

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a small 24C32-style EEPROM with 16-bit word addressing.
module i2c_eeprom_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]         DEV_ADDR = 7'h50,
  parameter int unsigned        DEPTH    = 16,
  parameter logic [DEPTH*8-1:0] INIT     = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_oe,
  output logic busy,
  output logic wr_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_e               state_q, state_d;
  logic [BitCntW-1:0]   cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic                 rack_ok_q, rack_ok_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic                 we;
  logic [7:0]           rx_byte, rd_byte;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    rack_ok_d  = rack_ok_q;
    we         = 1'b0;
    if (stop) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = StCtrl;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StCtrl, StAhi, StAlo, StWdata: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + BitCntW'(1);
            if (cnt_q == BitCntW'(7)) begin
              case (state_q)
                StCtrl: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = StAckCtrl;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                  end
                end
                StAhi: state_d = StAckAhi;
                StAlo: begin
                  ptr_d   = rx_byte[AW-1:0];
                  state_d = StAckAlo;
                end
                default: begin
                  we         = 1'b1;
                  wr_pulse_d = 1'b1;
                  ptr_d      = ptr_q + AW'(1);
                  state_d    = StAckW;
                end
              endcase
            end
          end
        end
        // First SCL fall after the byte starts the ACK, the next one ends it.
        StAckCtrl, StAckAhi, StAckAlo, StAckW: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              case (state_q)
                StAckCtrl: begin
                  if (shift_q[0]) begin
                    state_d  = StRdata;
                    sda_oe_d = ~rd_byte[7];
                  end else begin
                    state_d = StAhi;
                  end
                end
                StAckAhi: state_d = StAlo;
                default:  state_d = StWdata;
              endcase
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            cnt_d = cnt_q + BitCntW'(1);
            if (cnt_q == BitCntW'(7)) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + AW'(1);
              rack_ok_d = 1'b0;
              state_d   = StRack;
            end else begin
              sda_oe_d = ~rd_byte[3'd6 - cnt_q];
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            if (sda_s == NackBit) begin
              state_d = StIdle;
            end else begin
              rack_ok_d = 1'b1;
            end
          end else if (scl_fall && rack_ok_q) begin
            rack_ok_d = 1'b0;
            cnt_d     = '0;
            sda_oe_d  = ~rd_byte[7];
            state_d   = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[ptr_q] = rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      rack_ok_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT[8*i +: 8];
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      rack_ok_q  <= rack_ok_d;
      mem_q      <= mem_d;
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;

endmodule
